// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream
// and holds the core until the image is loaded and its checksum verifies.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, CSUM, DONE, ERR
  } state_t;

  localparam logic [31:0] CAP = 32'd1 << ADDR_W;

  state_t          state;
  state_t          nxt;
  logic [1:0]      bcnt;
  logic [ADDR_W:0] widx;
  logic [ADDR_W:0] widx_n;
  logic [31:0]     cnt;
  logic [31:0]     acc;
  logic [31:0]     shreg;
  logic [31:0]     word;
  logic            take;
  logic            last;
  logic            launch;
  logic            hdr_end;
  logic            dat_end;
  logic            sum_end;

  // byte 0 of each field ends up in bits 7:0
  assign word    = {in_data, shreg[31:8]};
  assign widx_n  = widx + 1'b1;
  assign take    = in_valid && in_ready;
  assign last    = take && (bcnt == 2'd3);
  assign launch  = start &&
                   (state == IDLE || state == DONE || state == ERR);
  assign hdr_end = last && (state == HDR);
  assign dat_end = last && (state == DATA);
  assign sum_end = last && (state == CSUM);

  // next-state decode; the flags above are mutually exclusive
  always_comb begin
    nxt = state;
    unique case (1'b1)
      launch:  nxt = HDR;
      hdr_end: nxt = (word > CAP)  ? ERR  :
                     (word == '0)  ? CSUM : DATA;
      dat_end: nxt = (32'(widx_n) == cnt) ? CSUM : DATA;
      sum_end: nxt = (word == acc) ? DONE : ERR;
      default: nxt = state;
    endcase
  end

  // state, datapath registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bcnt       <= '0;
      widx       <= '0;
      cnt        <= '0;
      acc        <= '0;
      shreg      <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_hold  <= 1'b1;
    end else begin
      state     <= nxt;
      imem_we   <= 1'b0;
      in_ready  <= (nxt == HDR) || (nxt == DATA) || (nxt == CSUM);
      busy      <= (nxt == HDR) || (nxt == DATA) || (nxt == CSUM);
      done      <= (nxt == DONE);
      error     <= (nxt == ERR);
      core_hold <= (nxt != DONE);
      if (launch) begin
        bcnt <= '0;
        widx <= '0;
        acc  <= '0;
      end else if (take) begin
        shreg <= word;
        bcnt  <= bcnt + 2'd1;
        if (hdr_end) cnt <= word;
        if (dat_end) begin
          imem_we    <= 1'b1;
          imem_waddr <= widx[ADDR_W-1:0];
          imem_wdata <= word;
          acc        <= acc + word;
          widx       <= widx_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed frames checked against
// a frame-level model of the loader.
module tb_imem_loader;

  localparam int AW  = 10;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          error;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  fr[$];
  logic [31:0] wq[$];
  logic [31:0] nw;
  int          acc_n;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) fr.push_back(8'(v >> (8 * i)));
  endtask

  function automatic logic [31:0] wsum();
    logic [31:0] s = '0;
    foreach (wq[i]) s += wq[i];
    return s;
  endfunction

  // frame: declared count, the words in wq, then checksum
  task automatic build(input logic [31:0] n, input logic [31:0] cs);
    fr.delete();
    nw = n;
    push32(n);
    foreach (wq[i]) push32(wq[i]);
    push32(cs);
  endtask

  function automatic logic model_ok();
    if (nw > 32'(CAP)) return 1'b0;
    return fr[fr.size()-1] == 8'(wsum() >> 24) &&
           fr[fr.size()-2] == 8'(wsum() >> 16) &&
           fr[fr.size()-3] == 8'(wsum() >> 8) &&
           fr[fr.size()-4] == 8'(wsum());
  endfunction

  function automatic int model_bytes();
    return (nw > 32'(CAP)) ? 4 : fr.size();
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_hold", core_hold, 1);
    chk("start_ready", in_ready, 1);
  endtask

  // mode 0: always valid, 1: alternate cycles, 2: random gaps
  task automatic run(input int mode, input int stop_after);
    int   k = 0;
    int   cyc = 0;
    logic v;
    logic rdy;
    logic exp_we;
    while (k < fr.size() && k < stop_after && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      v = (mode == 0) ? 1'b1 :
          (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = fr[k];
      rdy      = in_ready;
      @(posedge clk);
      #1;
      exp_we = v && rdy && k >= 4 && (k % 4) == 3 &&
               k < 4 + 4 * int'(nw);
      chk("imem_we", 32'(imem_we), 32'(exp_we));
      if (exp_we) begin
        chk("waddr", 32'(imem_waddr), 32'((k - 4) / 4));
        chk("wdata", imem_wdata, wq[(k - 4) / 4]);
      end
      if (v && rdy) k++;
      if (done || error) break;
    end
    in_valid = 1'b0;
    if (cyc >= 20000) chk("timeout", 32'(cyc), 0);
    acc_n = k;
  endtask

  task automatic outcome(input logic ok);
    chk("bytes", 32'(acc_n), 32'(model_bytes()));
    chk("done", 32'(done), 32'(ok));
    chk("error", 32'(error), 32'(!ok));
    chk("hold", 32'(core_hold), 32'(!ok));
    chk("ready", 32'(in_ready), 0);
    chk("busy", 32'(busy), 0);
  endtask

  task automatic frame(input int mode);
    do_start();
    run(mode, 1 << 30);
    outcome(model_ok());
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_in", 32'(core_hold), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_hold", 32'(core_hold), 1);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_busy", 32'(busy), 0);

    wq = '{32'h0000_0013, 32'h0010_0093};
    build(2, 32'h0010_00A6);
    frame(0);

    build(2, 32'h0010_00A7);
    frame(0);

    wq.delete();
    build(1025, 32'h0);
    frame(0);
    in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("ovf_we", 32'(imem_we), 0);
      chk("ovf_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;

    build(0, 32'h0);
    frame(1);
    frame(0);

    wq = '{$urandom(), $urandom()};
    build(2, wsum());
    do_start();
    run(0, 10);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = fr[10];
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_hold", 32'(core_hold), 1);
    chk("mrst_ready", 32'(in_ready), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_we", 32'(imem_we), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("mrst_nowr", 32'(imem_we), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    frame(0);

    for (int t = 0; t < 8; t++) begin
      wq.delete();
      repeat ($urandom_range(0, 6)) wq.push_back($urandom());
      build(32'(wq.size()),
            ($urandom_range(0, 2) == 0) ? wsum() ^ 32'h1 : wsum());
      frame(2);
    end

    wq.delete();
    for (int i = 0; i < CAP; i++) wq.push_back($urandom());
    build(32'(CAP), wsum());
    frame(0);
    chk("last_addr", 32'(imem_waddr), 32'(CAP - 1));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The fetch stage reads words from the imem ROM; this block fills the same imem over a byte stream before the core runs.
- Receives a framed program (header, words, checksum) on a valid/ready byte interface.
- Assembles little-endian 32-bit words and issues one-cycle imem write strobes.
- Holds the core (core_hold, wired to the pipeline stall/reset) until the load completes and the checksum verifies.

Parameters:
ADDR_W, 10, imem word-address width; capacity 2^ADDR_W words (1024 at default)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load; sampled only in IDLE, DONE or ERR
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  imem write strobe, one cycle per word
imem_waddr  output  ADDR_W  imem word address
imem_wdata  output  32  imem write data
core_hold  output  1  keep the core stalled/in reset
busy  output  1  load in progress
done  output  1  load finished, checksum matched
error  output  1  load failed (oversize count or checksum mismatch)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 except core_hold=1.
  - Byte counter, word counter, checksum and count registers are cleared.
  - Reset mid-load aborts at once. Words already written stay in imem; done stays 0.
- Byte accept: in_valid && in_ready on a rising edge. in_ready=1 only in HDR, DATA and CSUM.
- Frame format, all fields little-endian:
  - 4-byte word count N.
  - N×4 data bytes.
  - 4-byte checksum, equal to the sum of the N data words mod 2^32.
- States:
  - IDLE: start=1 → HDR. Clear the byte counter, word counter and checksum accumulator.
  - HDR: collect 4 bytes into N (32-bit). On the 4th accepted byte:
    - N > 2^ADDR_W → ERR.
    - N=0 → CSUM.
    - otherwise → DATA.
  - DATA: shift bytes into the word register (byte 0 lands in bits 7:0). On the 4th byte of each word:
    - Next cycle: imem_we=1, imem_waddr=word index (0..N-1), imem_wdata=assembled word. Write latency is exactly 1 cycle after the 4th byte is accepted.
    - Add the word to the checksum accumulator (32-bit, wrapping).
    - Increment the word index. After word N-1 → CSUM.
  - CSUM: collect 4 bytes. On the 4th byte, compare with the accumulator: match → DONE, else → ERR.
  - DONE: done=1, core_hold=0. start=1 → HDR (reload).
  - ERR: error=1, core_hold=1, in_ready=0. start=1 → HDR.
- busy=1 in HDR, DATA and CSUM. core_hold=0 only in DONE.
- Entering HDR from DONE or ERR clears done and error in the same cycle; core_hold rises in that cycle.
- start while busy is ignored.
- in_valid gaps (0 for any number of cycles) stall progress. There is no timeout.
- imem_we is never asserted outside DATA's write cycle; at most 1 write per 4 accepted bytes.
- N = 2^ADDR_W is legal. Addresses run 0..2^ADDR_W-1 and never wrap.
- Address/data outputs hold their last value when imem_we=0.
- The accumulator and word index are sized to 32 bits and ADDR_W+1 bits respectively, so the terminal count compares correctly.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → state IDLE, core_hold=1, in_ready=0, done=0, error=0, imem_we=0.
- Nominal 2-word load: start; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00, checksum A6 00 10 00.
  - Writes (addr 0, 0x00000013) and (addr 1, 0x00100093), each exactly 1 cycle after its 4th byte.
  - Then done=1, core_hold=0.
- Checksum mismatch: same frame with checksum A7 00 10 00 → error=1, done=0, core_hold=1, in_ready=0; both writes still occurred.
- Oversize count: header 01 04 00 00 (N=1025, ADDR_W=10) → ERR right after the 4th header byte; no imem_we ever asserted.
- Throttled stream with N=0 and checksum 00 00 00 00:
  - in_valid toggles 1/0 on alternate cycles → done=1 after 8 accepted bytes; zero writes.
  - Then start again → done clears and the loader is back in HDR.
- Async reset mid-DATA: drop rst_n between the 2nd and 3rd byte of word 1 → immediate IDLE, core_hold=1, no further writes; a fresh start reloads correctly.
